// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   state_t : sequencer FSM encoding (also exported on the debug port)
//   OP_*    : encoding of req_op
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_wait_ctr.sv
// Saturating wait counter used to bound how long the sequencer waits for a
// unit to report ready.
//   clock, reset_n : clock / async active-low reset
//   clear          : synchronous clear to 0 (wins over enable)
//   enable         : count up by one, saturating at TIMEOUT
//   terminal       : count == TIMEOUT-1 (abort point)
module multdiv_wait_ctr #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign terminal = (count_q == TERM);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared iterative multiplier and divider for the pipeline.
// Accepts one request, latches its operands, pulses the selected unit's
// start, waits (bounded) for its ready, and returns the captured response.
//   clock, reset_n          : clock / async active-low reset
//   req_*                   : request from execute (req_ready back)
//   flush                   : kills any in-flight operation
//   unit_a, unit_b          : latched operands, driven to both units
//   mult_start, div_start   : one-cycle start pulse to the selected unit
//   mult_*/div_* rdy/result/exc : unit outputs
//   resp_*                  : response to writeback (resp_ready back)
//   stall                   : high whenever the sequencer is busy
//   dbg_state               : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until the
// transfer; the consumer may drive ready independently of valid.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  output logic             req_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             mult_start,
  output logic             div_start,
  input  logic             mult_rdy,
  input  logic             div_rdy,
  input  logic [WIDTH-1:0] mult_result,
  input  logic [WIDTH-1:0] div_result,
  input  logic             mult_exc,
  input  logic             div_exc,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_exception,
  output logic             resp_timeout,
  output logic [RD_W-1:0]  resp_rd,
  output logic             stall,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             op_q, exc_q, timeout_q;
  logic [RD_W-1:0]  rd_q;

  logic accept, capture_rdy, capture_to, ctr_clear, ctr_en, ctr_term;
  logic sel_rdy, sel_exc;
  logic [WIDTH-1:0] sel_result;

  // Only the unit that owns the current op is ever looked at.
  assign sel_rdy    = (op_q == OP_DIV) ? div_rdy    : mult_rdy;
  assign sel_exc    = (op_q == OP_DIV) ? div_exc    : mult_exc;
  assign sel_result = (op_q == OP_DIV) ? div_result : mult_result;

  // The counter is held clear in IDLE and runs from the START cycle on, so
  // the abort lands TIMEOUT cycles after the accept edge.
  multdiv_wait_ctr #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_ctr (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (ctr_clear),
    .enable   (ctr_en),
    .terminal (ctr_term)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture_rdy = 1'b0;
    capture_to  = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ctr_clear = 1'b1;
        if (req_valid && !flush) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Unit ready is not looked at here: it may still be high from the
        // previous operation until the start pulse lands.
        ctr_en  = 1'b1;
        state_d = flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        ctr_en = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (sel_rdy) begin
          // A ready arriving on the abort cycle still wins.
          capture_rdy = 1'b1;
          state_d     = ST_DONE;
        end else if (ctr_term) begin
          capture_to = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_MULT;
      rd_q      <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= req_a;
        b_q  <= req_b;
        op_q <= req_op;
        rd_q <= req_rd;
      end
      if (capture_rdy) begin
        result_q  <= sel_result;
        exc_q     <= sel_exc;
        timeout_q <= 1'b0;
      end else if (capture_to) begin
        result_q  <= '0;
        exc_q     <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  assign req_ready      = (state_q == ST_IDLE) && !flush;
  assign unit_a         = a_q;
  assign unit_b         = b_q;
  assign mult_start     = (state_q == ST_START) && (op_q == OP_MULT);
  assign div_start      = (state_q == ST_START) && (op_q == OP_DIV);
  assign resp_valid     = (state_q == ST_DONE);
  assign resp_result    = result_q;
  assign resp_exception = exc_q;
  assign resp_timeout   = timeout_q;
  assign resp_rd        = rd_q;
  assign stall          = (state_q != ST_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;
  import multdiv_pkg::*;

  localparam int WIDTH = 32;
  localparam int RD_W  = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             req_valid = 1'b0;
  logic             req_op = 1'b0;
  logic [WIDTH-1:0] req_a = '0, req_b = '0;
  logic [RD_W-1:0]  req_rd = '0;
  logic             req_ready;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] unit_a, unit_b;
  logic             mult_start, div_start;
  logic             mult_rdy, div_rdy;
  logic [WIDTH-1:0] mult_result, div_result;
  logic             mult_exc, div_exc;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [WIDTH-1:0] resp_result;
  logic             resp_exception, resp_timeout;
  logic [RD_W-1:0]  resp_rd;
  logic             stall;
  state_t           dbg_state;

  multdiv_sequencer #(.WIDTH(WIDTH), .RD_W(RD_W), .TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_rd(req_rd), .req_ready(req_ready), .flush(flush),
    .unit_a(unit_a), .unit_b(unit_b),
    .mult_start(mult_start), .div_start(div_start),
    .mult_rdy(mult_rdy), .div_rdy(div_rdy),
    .mult_result(mult_result), .div_result(div_result),
    .mult_exc(mult_exc), .div_exc(div_exc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_exception(resp_exception),
    .resp_timeout(resp_timeout), .resp_rd(resp_rd),
    .stall(stall), .dbg_state(dbg_state)
  );

  // ---------------- behavioural unit models ----------------
  // Ready rises L cycles after the start pulse and stays high until the
  // next start (so it is stale at the following START).
  int mul_lat = 17;
  int div_lat = 33;
  bit div_hang = 1'b0;
  int m_cnt, d_cnt;
  logic signed [63:0] prod;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0; mult_rdy <= 1'b0; mult_result <= '0; mult_exc <= 1'b0;
    end else if (mult_start) begin
      prod = $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
      mult_exc    <= (prod != {{32{prod[31]}}, prod[31:0]});
      mult_result <= (prod != {{32{prod[31]}}, prod[31:0]}) ? '0 : prod[31:0];
      mult_rdy    <= (mul_lat == 1);
      m_cnt = mul_lat - 1;
    end else if (m_cnt != 0) begin
      if (m_cnt == 1) mult_rdy <= 1'b1;
      m_cnt = m_cnt - 1;
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_cnt = 0; div_rdy <= 1'b0; div_result <= '0; div_exc <= 1'b0;
    end else if (div_start) begin
      div_exc    <= (unit_b == 0);
      div_result <= (unit_b == 0) ? '0 : WIDTH'($signed(unit_a) / $signed(unit_b));
      div_rdy    <= 1'b0;
      d_cnt = div_hang ? 0 : div_lat - 1;
    end else if (d_cnt != 0) begin
      if (d_cnt == 1) div_rdy <= 1'b1;
      d_cnt = d_cnt - 1;
    end
  end

  // start-pulse monitors (sampled mid-cycle)
  int n_ms = 0, n_ds = 0;
  always @(negedge clock) begin
    if (mult_start) n_ms <= n_ms + 1;
    if (div_start)  n_ds <= n_ds + 1;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with the sequencer idle; returns at the negedge of
  // the START cycle with t_acc = index of the accept edge.
  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, output int t_acc);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    t_acc = cyc + 1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
  endtask

  // Waits (bounded) for resp_valid; returns cycles since the accept edge.
  task automatic wait_resp(input int t_acc, output int delta);
    delta = -1;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid) begin
        delta = cyc - t_acc;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Checks a full response against the expected queue (lat, result, exc, to, rd)
  // and lets the handshake complete (resp_ready assumed high).
  task automatic expect_resp(input string tag, input int t_acc);
    int d;
    wait_resp(t_acc, d);
    check({tag, "_lat"}, 64'(d), exp_q.pop_front());
    check({tag, "_res"}, 64'(resp_result), exp_q.pop_front());
    check({tag, "_exc"}, 64'(resp_exception), exp_q.pop_front());
    check({tag, "_to"},  64'(resp_timeout), exp_q.pop_front());
    check({tag, "_rd"},  64'(resp_rd), exp_q.pop_front());
    @(negedge clock);
  endtask

  task automatic push_exp(input int lat, input logic [31:0] res, input logic exc,
                          input logic to, input logic [4:0] rd);
    exp_q.push_back(64'(lat));
    exp_q.push_back(64'(res));
    exp_q.push_back(64'(exc));
    exp_q.push_back(64'(to));
    exp_q.push_back(64'(rd));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t, ms0, ds0, d;
    bit ok;
    logic [31:0] hold_res;
    logic [4:0]  hold_rd;

    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_unit_a", 64'(unit_a), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // MULT 7 * -3
    ms0 = n_ms;
    send(OP_MULT, 32'd7, 32'hFFFF_FFFD, 5'd9, t);
    check("mul1_start", 64'(mult_start), 64'd1);
    check("mul1_div_start", 64'(div_start), 64'd0);
    check("mul1_stall", 64'(stall), 64'd1);
    push_exp(18, 32'hFFFF_FFEB, 1'b0, 1'b0, 5'd9);
    expect_resp("mul1", t);
    check("mul1_pulses", 64'(n_ms - ms0), 64'd1);
    check("mul1_idle", 64'(req_ready), 64'd1);

    // MULT overflow: unit exception, no timeout
    send(OP_MULT, 32'h4000_0000, 32'd4, 5'd3, t);
    push_exp(18, 32'd0, 1'b1, 1'b0, 5'd3);
    expect_resp("mulovf", t);

    // DIV that never completes -> timeout abort
    div_hang = 1'b1;
    send(OP_DIV, 32'd10, 32'd2, 5'd4, t);
    push_exp(40, 32'd0, 1'b1, 1'b1, 5'd4);
    expect_resp("divto", t);
    div_hang = 1'b0;

    // DIV whose ready coincides with the abort cycle: ready wins
    div_lat = 39;
    send(OP_DIV, 32'd100, 32'd7, 5'd6, t);
    push_exp(40, 32'd14, 1'b0, 1'b0, 5'd6);
    expect_resp("divedge", t);
    div_lat = 33;

    // flush and req_valid together in IDLE: not accepted
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd1; req_b = 32'd1; flush = 1'b1;
    #1 check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("flush_noaccept", 64'(stall), 64'd0);

    // flush 5 cycles into WAIT
    send(OP_MULT, 32'd5, 32'd5, 5'd2, t);
    repeat (6) @(negedge clock);
    check("fl_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    check("fl_idle", 64'(dbg_state), 64'(ST_IDLE));
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (resp_valid || stall) ok = 1'b0;
      @(negedge clock);
    end
    check("fl_no_resp", 64'(ok), 64'd1);
    // mult_rdy is now stale-high from the flushed op
    check("stale_rdy_pre", 64'(mult_rdy), 64'd1);
    send(OP_MULT, 32'd2, 32'd3, 5'd8, t);
    check("stale_rdy_start", 64'(mult_rdy), 64'd1);
    push_exp(18, 32'd6, 1'b0, 1'b0, 5'd8);
    expect_resp("mul23", t);

    // back-to-back DIV after MULT: only div_start pulses, stale mult_rdy ignored
    ms0 = n_ms; ds0 = n_ds;
    send(OP_DIV, 32'hFFFF_FFF6, 32'd3, 5'd11, t);
    push_exp(34, 32'hFFFF_FFFD, 1'b0, 1'b0, 5'd11);
    expect_resp("divneg", t);
    check("b2b_mult_pulses", 64'(n_ms - ms0), 64'd0);
    check("b2b_div_pulses", 64'(n_ds - ds0), 64'd1);
    send(OP_MULT, 32'd9, 32'd9, 5'd12, t);
    push_exp(18, 32'd81, 1'b0, 1'b0, 5'd12);
    expect_resp("b2b_mul", t);
    check("b2b_mult_pulses2", 64'(n_ms - ms0), 64'd1);

    // DIV by zero with writeback back-pressure for 10 cycles
    resp_ready = 1'b0;
    send(OP_DIV, 32'd50, 32'd0, 5'd13, t);
    wait_resp(t, d);
    check("bp_lat", 64'(d), 64'd34);
    hold_res = resp_result; hold_rd = resp_rd;
    check("bp_exc", 64'(resp_exception), 64'd1);
    check("bp_res", 64'(resp_result), 64'd0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!resp_valid || req_ready || !stall || resp_result !== hold_res ||
          resp_rd !== hold_rd || resp_exception !== 1'b1 || resp_timeout !== 1'b0) ok = 1'b0;
      @(negedge clock);
    end
    check("bp_stable", 64'(ok), 64'd1);
    resp_ready = 1'b1;
    @(negedge clock);
    check("bp_released", 64'(dbg_state), 64'(ST_IDLE));

    // async reset in the middle of WAIT
    send(OP_MULT, 32'd3, 32'd4, 5'd15, t);
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_unit_a", 64'(unit_a), 64'd0);
    check("arst_rd", 64'(resp_rd), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
